ia_reader: RTL

IA_READER -- requirements
Module: ia_reader

---
 rtl/ia_reader_pkg.sv | 41 ++++
 rtl/ia_rsp_fifo.sv | 52 +++++
 rtl/ia_reader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ia_reader_pkg.sv
// Shared definitions for the IA tile reader: FSM state encoding, credit
// counter width and the ICB bus channel types.
package ia_reader_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;

  // Wide enough to count up to 16 outstanding reads plus buffered words.
  localparam int CREDIT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } ia_state_e;

  typedef struct packed {
    logic              valid;
    logic [ICB_AW-1:0] addr;
    logic              read;
    logic [ICB_DW-1:0] wdata;
    logic [3:0]        wmask;
    logic [1:0]        size;
  } icb_cmd_m_t;

  typedef struct packed {
    logic ready;
  } icb_cmd_s_t;

  typedef struct packed {
    logic              valid;
    logic [ICB_DW-1:0] rdata;
    logic              err;
  } icb_rsp_s_t;

  typedef struct packed {
    logic ready;
  } icb_rsp_m_t;

endpackage

// File: rtl/ia_rsp_fifo.sv
// Synchronous response FIFO for the IA reader. Read data is presented
// combinationally from the head entry; push on a full FIFO is accepted
// only together with a pop, and pop on an empty FIFO is ignored.
module ia_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ia_reader.sv
// IA tile reader: walks a 2-D tile of 32-bit words over ICB, one tile per
// external grant, and streams the words downstream with row_last/read_done.
// Optional macro IA_READER_RSP_ERR_EN adds a sticky rd_err output.
module ia_reader
  import ia_reader_pkg::*;
#(
  parameter int REG_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_cfg,
  input  logic [REG_WIDTH-1:0] src_base,
  input  logic [REG_WIDTH-1:0] src_row_stride_b,
  input  logic [REG_WIDTH-1:0] tile_stride_b,
  input  logic [REG_WIDTH-1:0] row_words,
  input  logic [REG_WIDTH-1:0] rows,
  input  logic [REG_WIDTH-1:0] tile_count,
  output logic                 read_ia_req,
  input  logic                 read_ia_granted,
  output icb_cmd_m_t           icb_cmd_m,
  input  icb_cmd_s_t           icb_cmd_s,
  input  icb_rsp_s_t           icb_rsp_s,
  output icb_rsp_m_t           icb_rsp_m,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [31:0]          data_out,
  output logic                 row_last,
  output logic                 read_done,
  output logic                 ia_load_over
`ifdef IA_READER_RSP_ERR_EN
  ,
  output logic                 rd_err
`endif
);

  localparam int FCNT_W = $clog2(MAX_OUTSTANDING) + 1;

  function automatic logic is_last(input logic [REG_WIDTH-1:0] cnt,
                                   input logic [REG_WIDTH-1:0] total);
    return cnt == (total - REG_WIDTH'(1));
  endfunction

  ia_state_e state, state_nxt;

  // Latched configuration
  logic [REG_WIDTH-1:0] row_stride_r;
  logic [REG_WIDTH-1:0] tile_stride_r;
  logic [REG_WIDTH-1:0] row_words_r;
  logic [REG_WIDTH-1:0] rows_r;
  logic [REG_WIDTH-1:0] tiles_r;

  // Incremental address generators
  logic [REG_WIDTH-1:0] tile_base_r;
  logic [REG_WIDTH-1:0] row_addr_r;
  logic [REG_WIDTH-1:0] cmd_addr_r;

  // Issue-side, response-side and output-side position counters
  logic [REG_WIDTH-1:0] col_cnt;
  logic [REG_WIDTH-1:0] row_cnt;
  logic [REG_WIDTH-1:0] tile_cnt;
  logic [REG_WIDTH-1:0] rsp_col_cnt;
  logic [REG_WIDTH-1:0] out_row_cnt;

  logic [CREDIT_W-1:0]  inflight;
  logic [CREDIT_W-1:0]  used;
  logic [FCNT_W-1:0]    fifo_count;
  logic [32:0]          fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;

  logic cfg_zero;
  logic start;
  logic credit_ok;
  logic cmd_fire;
  logic rsp_fire;
  logic pop;
  logic col_last;
  logic row_last_iss;
  logic tile_cmds_done;
  logic last_tile;
  logic rsp_row_last;

  assign cfg_zero       = (tile_count == '0) | (rows == '0) | (row_words == '0);
  assign start          = (state == IDLE) & init_cfg;
  assign used           = inflight + CREDIT_W'(fifo_count);
  assign credit_ok      = used < CREDIT_W'(MAX_OUTSTANDING);
  assign cmd_fire       = icb_cmd_m.valid & icb_cmd_s.ready;
  // Responses with nothing in flight belong to reads discarded by reset.
  assign rsp_fire       = icb_rsp_s.valid & (inflight != '0);
  assign pop            = data_valid & data_ready;
  assign col_last       = is_last(col_cnt, row_words_r);
  assign row_last_iss   = is_last(row_cnt, rows_r);
  assign tile_cmds_done = cmd_fire & col_last & row_last_iss;
  assign last_tile      = is_last(tile_cnt, tiles_r);
  assign rsp_row_last   = is_last(rsp_col_cnt, row_words_r);

  assign read_ia_req    = (state == REQ);
  assign icb_rsp_m      = '{ready: 1'b1};
  assign data_valid     = ~fifo_empty;
  assign data_out       = fifo_rdata[31:0];
  assign row_last       = data_valid & fifo_rdata[32];
  assign read_done      = pop & fifo_rdata[32] & is_last(out_row_cnt, rows_r);

  // ICB command: always a 32-bit read; address held until accepted.
  always_comb begin
    icb_cmd_m       = '0;
    icb_cmd_m.valid = (state == ISSUE) & credit_ok;
    icb_cmd_m.addr  = ICB_AW'(cmd_addr_r);
    icb_cmd_m.read  = 1'b1;
    icb_cmd_m.size  = 2'b10;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init_cfg && !cfg_zero) state_nxt = REQ;
      REQ:     if (read_ia_granted)       state_nxt = ISSUE;
      ISSUE:   if (tile_cmds_done)        state_nxt = DRAIN;
      DRAIN:   if (read_done)             state_nxt = last_tile ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration latch and address walkers (data path, no reset).
  always_ff @(posedge clk) begin
    if (start) begin
      row_stride_r  <= src_row_stride_b;
      tile_stride_r <= tile_stride_b;
      row_words_r   <= row_words;
      rows_r        <= rows;
      tiles_r       <= tile_count;
      tile_base_r   <= src_base;
      row_addr_r    <= src_base;
      cmd_addr_r    <= src_base;
    end else if (cmd_fire) begin
      if (col_last && row_last_iss) begin
        tile_base_r <= tile_base_r + tile_stride_r;
        row_addr_r  <= tile_base_r + tile_stride_r;
        cmd_addr_r  <= tile_base_r + tile_stride_r;
      end else if (col_last) begin
        row_addr_r  <= row_addr_r + row_stride_r;
        cmd_addr_r  <= row_addr_r + row_stride_r;
      end else begin
        cmd_addr_r  <= cmd_addr_r + REG_WIDTH'(4);
      end
    end
  end

  // Position counters for issue, response tagging and output framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      tile_cnt    <= '0;
      rsp_col_cnt <= '0;
      out_row_cnt <= '0;
    end else if (start) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      tile_cnt    <= '0;
      rsp_col_cnt <= '0;
      out_row_cnt <= '0;
    end else begin
      if (cmd_fire) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last_iss ? '0 : row_cnt + REG_WIDTH'(1);
        end else begin
          col_cnt <= col_cnt + REG_WIDTH'(1);
        end
      end
      if (rsp_fire) begin
        rsp_col_cnt <= rsp_row_last ? '0 : rsp_col_cnt + REG_WIDTH'(1);
      end
      if (pop && fifo_rdata[32]) begin
        out_row_cnt <= is_last(out_row_cnt, rows_r) ? '0 : out_row_cnt + REG_WIDTH'(1);
      end
      if (read_done) begin
        tile_cnt <= tile_cnt + REG_WIDTH'(1);
      end
    end
  end

  // In-flight read count: accept and response together cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({cmd_fire, rsp_fire})
        2'b10:   inflight <= inflight + CREDIT_W'(1);
        2'b01:   inflight <= inflight - CREDIT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Completion flag: set immediately for an empty job, else after last tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ia_load_over <= 1'b0;
    end else if (start) begin
      ia_load_over <= cfg_zero;
    end else if ((state == DRAIN) && read_done && last_tile) begin
      ia_load_over <= 1'b1;
    end
  end

`ifdef IA_READER_RSP_ERR_EN
  // Sticky response error flag, cleared by a new configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err <= 1'b0;
    end else if (start) begin
      rd_err <= 1'b0;
    end else if (rsp_fire && icb_rsp_s.err) begin
      rd_err <= 1'b1;
    end
  end
`else
  logic unused_rsp_err;
  assign unused_rsp_err = icb_rsp_s.err;
`endif

  ia_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (33)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_fire),
    .wdata ({rsp_row_last, icb_rsp_s.rdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule
